// File: rtl/vc32_mem_arbiter.sv
// Two-master round-robin arbiter in front of the byte-serial memory sequencer:
// one whole transaction per grant, completion routed to the owner, watchdog release.
module vc32_mem_arbiter #(
   parameter int RV      = 16,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic [RV-2:0]   c_raddr,
   input  logic [RV/8-1:0] c_rreq,
   input  logic [RV-2:0]   c_waddr,
   input  logic [RV/8-1:0] c_wmask,
   input  logic [RV-1:0]   c_wdata,
   output logic            c_rdone,
   output logic            c_wdone,
   input  logic [RV-2:0]   d_raddr,
   input  logic [RV/8-1:0] d_rreq,
   input  logic [RV-2:0]   d_waddr,
   input  logic [RV/8-1:0] d_wmask,
   input  logic [RV-1:0]   d_wdata,
   output logic            d_rdone,
   output logic            d_wdone,
   output logic [RV-2:0]   m_raddr,
   output logic [RV/8-1:0] m_rreq,
   output logic [RV-2:0]   m_waddr,
   output logic [RV/8-1:0] m_wmask,
   output logic [RV-1:0]   m_wdata,
   input  logic            m_rdone,
   input  logic            m_wdone,
   output logic            owner,
   output logic            busy,
   output logic            err,
   input  logic            err_clr
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t           state;
   logic             kind_w;
   logic             last;
   logic [CNT_W-1:0] wd_cnt;

   logic             c_pend;
   logic             d_pend;
   logic             grant_d;
   logic [RV-2:0]    sel_raddr;
   logic [RV/8-1:0]  sel_rreq;
   logic [RV-2:0]    sel_waddr;
   logic [RV/8-1:0]  sel_wmask;
   logic [RV-1:0]    sel_wdata;
   logic             exp_done;
   logic             expire;
   logic             finish;

   assign c_pend  = (|c_wmask) | (|c_rreq);
   assign d_pend  = (|d_wmask) | (|d_rreq);
   // On a tie the master that did not own the bus last time wins.
   assign grant_d = d_pend & (~c_pend | ~last);

   assign sel_raddr = grant_d ? d_raddr : c_raddr;
   assign sel_rreq  = grant_d ? d_rreq  : c_rreq;
   assign sel_waddr = grant_d ? d_waddr : c_waddr;
   assign sel_wmask = grant_d ? d_wmask : c_wmask;
   assign sel_wdata = grant_d ? d_wdata : c_wdata;

   assign busy     = (state == S_BUSY);
   assign exp_done = kind_w ? m_wdone : m_rdone;
   assign expire   = (TIMEOUT != 0) && busy && (wd_cnt == CNT_LAST) && !exp_done;
   assign finish   = busy && (exp_done || expire);

   // Completion (real or watchdog-forced) goes only to the owner's port of the current kind.
   assign c_wdone = finish & ~owner &  kind_w;
   assign c_rdone = finish & ~owner & ~kind_w;
   assign d_wdone = finish &  owner &  kind_w;
   assign d_rdone = finish &  owner & ~kind_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         m_raddr <= '0;
         m_rreq  <= '0;
         m_waddr <= '0;
         m_wmask <= '0;
         m_wdata <= '0;
         owner   <= 1'b0;
         kind_w  <= 1'b0;
         last    <= 1'b1;
         wd_cnt  <= '0;
         err     <= 1'b0;
      end else begin
         if (expire) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               wd_cnt <= '0;
               if (ena && (c_pend || d_pend)) begin
                  owner <= grant_d;
                  if (|sel_wmask) begin
                     m_waddr <= sel_waddr;
                     m_wmask <= sel_wmask;
                     m_wdata <= sel_wdata;
                     m_rreq  <= '0;
                     kind_w  <= 1'b1;
                  end else begin
                     m_raddr <= sel_raddr;
                     m_rreq  <= sel_rreq;
                     m_wmask <= '0;
                     kind_w  <= 1'b0;
                  end
                  state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (finish) begin
                  m_rreq  <= '0;
                  m_wmask <= '0;
                  last    <= owner;
                  wd_cnt  <= '0;
                  state   <= S_IDLE;
               end else if (TIMEOUT != 0) begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vc32_mem_arbiter.sv
// Directed bench for vc32_mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_vc32_mem_arbiter;

   localparam int RV = 16;
   localparam int TO = 8;
   localparam int AW = RV - 1;
   localparam int LW = RV / 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b0;
   logic [AW-1:0] c_raddr = '0, c_waddr = '0, d_raddr = '0, d_waddr = '0;
   logic [LW-1:0] c_rreq = '0, c_wmask = '0, d_rreq = '0, d_wmask = '0;
   logic [RV-1:0] c_wdata = '0, d_wdata = '0;
   logic          m_rdone = 1'b0, m_wdone = 1'b0, err_clr = 1'b0;
   logic          c_rdone, c_wdone, d_rdone, d_wdone;
   logic [AW-1:0] m_raddr, m_waddr;
   logic [LW-1:0] m_rreq, m_wmask;
   logic [RV-1:0] m_wdata;
   logic          owner, busy, err;

   vc32_mem_arbiter #(.RV(RV), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .c_raddr(c_raddr), .c_rreq(c_rreq), .c_waddr(c_waddr), .c_wmask(c_wmask),
      .c_wdata(c_wdata), .c_rdone(c_rdone), .c_wdone(c_wdone),
      .d_raddr(d_raddr), .d_rreq(d_rreq), .d_waddr(d_waddr), .d_wmask(d_wmask),
      .d_wdata(d_wdata), .d_rdone(d_rdone), .d_wdone(d_wdone),
      .m_raddr(m_raddr), .m_rreq(m_rreq), .m_waddr(m_waddr), .m_wmask(m_wmask),
      .m_wdata(m_wdata), .m_rdone(m_rdone), .m_wdone(m_wdone),
      .owner(owner), .busy(busy), .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Environment: sequencer answers after seq_lat request cycles (0 = never); masters
   // drop a request field when they see its done unless told to keep re-requesting.
   int   seq_lat = 0;
   int   age = 0;
   logic hold_c = 1'b0, hold_d = 1'b0;
   logic prev_busy = 1'b0;
   int   start_cyc = 0;
   int   n_cw = 0, n_cr = 0, n_dw = 0, n_dr = 0;
   int   t_cw = 0, t_cr = 0, t_dw = 0, t_dr = 0;
   logic grants[$];

   // Model: the transaction currently on the bus and the arbitration history.
   logic          md_act, md_own, md_wr, md_last, md_err;
   logic [LW-1:0] md_lanes;
   logic [AW-1:0] md_raddr, md_waddr;
   logic [RV-1:0] md_wdata;
   int            md_age;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s (cycle %0d): got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      md_act = 1'b0; md_own = 1'b0; md_wr = 1'b0; md_last = 1'b1; md_err = 1'b0;
      md_lanes = '0; md_raddr = '0; md_waddr = '0; md_wdata = '0; md_age = 0;
   endtask

   function automatic logic model_hit();
      return md_act && (md_wr ? m_wdone : m_rdone);
   endfunction

   function automatic logic model_expire();
      return md_act && (md_age == TO) && !model_hit();
   endfunction

   task automatic compare_model();
      logic fin;
      fin = model_hit() || model_expire();
      chk("m_rreq",  m_rreq,  (md_act && !md_wr) ? md_lanes : '0);
      chk("m_wmask", m_wmask, (md_act &&  md_wr) ? md_lanes : '0);
      chk("m_raddr", m_raddr, md_raddr);
      chk("m_waddr", m_waddr, md_waddr);
      chk("m_wdata", m_wdata, md_wdata);
      chk("busy",    busy,    md_act);
      chk("owner",   owner,   md_own);
      chk("err",     err,     md_err);
      chk("c_wdone", c_wdone, fin && !md_own &&  md_wr);
      chk("c_rdone", c_rdone, fin && !md_own && !md_wr);
      chk("d_wdone", d_wdone, fin &&  md_own &&  md_wr);
      chk("d_rdone", d_rdone, fin &&  md_own && !md_wr);
   endtask

   task automatic model_step();
      logic cp, dp, pick_d, hit, exp_to;
      logic [LW-1:0] wm;
      if (!rst_n) begin
         model_reset();
         return;
      end
      hit = model_hit();
      exp_to = model_expire();
      if (exp_to) md_err = 1'b1;
      else if (err_clr) md_err = 1'b0;
      if (md_act) begin
         if (hit || exp_to) begin
            md_act = 1'b0;
            md_last = md_own;
         end else begin
            md_age++;
         end
      end else begin
         cp = (c_wmask != 0) || (c_rreq != 0);
         dp = (d_wmask != 0) || (d_rreq != 0);
         if (ena && (cp || dp)) begin
            pick_d = (cp && dp) ? !md_last : dp;
            wm = pick_d ? d_wmask : c_wmask;
            if (wm != 0) begin
               md_wr = 1'b1;
               md_lanes = wm;
               md_waddr = pick_d ? d_waddr : c_waddr;
               md_wdata = pick_d ? d_wdata : c_wdata;
            end else begin
               md_wr = 1'b0;
               md_lanes = pick_d ? d_rreq : c_rreq;
               md_raddr = pick_d ? d_raddr : c_raddr;
            end
            md_own = pick_d;
            md_act = 1'b1;
            md_age = 1;
         end
      end
   endtask

   task automatic tick();
      logic s_cw, s_cr, s_dw, s_dr;
      @(negedge clk);
      compare_model();
      s_cw = c_wdone; s_cr = c_rdone; s_dw = d_wdone; s_dr = d_rdone;
      if (s_cw) begin n_cw++; t_cw = cyc; end
      if (s_cr) begin n_cr++; t_cr = cyc; end
      if (s_dw) begin n_dw++; t_dw = cyc; end
      if (s_dr) begin n_dr++; t_dr = cyc; end
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      if (busy && !prev_busy) begin
         grants.push_back(owner);
         start_cyc = cyc;
      end
      prev_busy = busy;
      if (s_cw && !hold_c) c_wmask = '0;
      if (s_cr && !hold_c) c_rreq = '0;
      if (s_dw && !hold_d) d_wmask = '0;
      if (s_dr && !hold_d) d_rreq = '0;
      if (m_wmask != 0 || m_rreq != 0) age++;
      else age = 0;
      m_wdone = (m_wmask != 0) && (age == seq_lat);
      m_rdone = (m_rreq != 0) && (age == seq_lat);
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n;
      n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      if (busy) chk({name, "_timeout"}, 1, 0);
   endtask

   task automatic drain(input string name, input int limit);
      int n;
      n = 0;
      while ((busy || c_rreq != 0 || c_wmask != 0 || d_rreq != 0 || d_wmask != 0) && n < limit) begin
         tick();
         n++;
      end
      if (busy) chk({name, "_drain_timeout"}, 1, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_wdone = 1'b0;
      m_rdone = 1'b0;
      age = 0;
      model_reset();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_req", {m_rreq, m_wmask}, 0);
      chk("rst_owner", owner, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      ena = 1'b1;
      tick();

      // 1: C write, sequencer completes in BUSY cycle 6
      seq_lat = 6;
      c_waddr = 15'h1234; c_wdata = 16'hbeef; c_wmask = 2'b11;
      tick();
      chk("t1_wmask_c1", m_wmask, 2'b11);
      chk("t1_waddr", m_waddr, 15'h1234);
      chk("t1_wdata", m_wdata, 16'hbeef);
      chk("t1_rreq", m_rreq, 0);
      wait_idle("t1", 20);
      chk("t1_wdone_cycle", t_cw - start_cyc + 1, 6);
      chk("t1_wdone_count", n_cw, 1);
      chk("t1_no_dwdone", n_dw, 0);
      chk("t1_wmask_c7", m_wmask, 0);

      // 2: both reads pending from reset, masters keep re-requesting
      do_reset();
      grants.delete();
      seq_lat = 2; hold_c = 1'b1; hold_d = 1'b1;
      c_raddr = 15'h0100; c_rreq = 2'b11;
      d_raddr = 15'h0200; d_rreq = 2'b01;
      repeat (13) tick();
      hold_c = 1'b0; hold_d = 1'b0;
      drain("t2", 40);
      chk("t2_ngrants", grants.size() >= 4, 1);
      if (grants.size() >= 4) begin
         chk("t2_grant0", grants[0], 0);
         chk("t2_grant1", grants[1], 1);
         chk("t2_grant2", grants[2], 0);
         chk("t2_grant3", grants[3], 1);
      end

      // 3: D with write and read pending: write first, read on the next grant
      seq_lat = 3;
      d_waddr = 15'h0abc; d_wdata = 16'h5a5a; d_wmask = 2'b01;
      d_raddr = 15'h0def; d_rreq = 2'b10;
      tick();
      chk("t3_owner_w", owner, 1);
      chk("t3_wmask", m_wmask, 2'b01);
      chk("t3_rreq_w", m_rreq, 0);
      chk("t3_waddr", m_waddr, 15'h0abc);
      wait_idle("t3w", 20);
      tick();
      chk("t3_rreq", m_rreq, 2'b10);
      chk("t3_wmask_r", m_wmask, 0);
      chk("t3_raddr", m_raddr, 15'h0def);
      wait_idle("t3r", 20);
      chk("t3_rdone_cycle", t_dr - start_cyc + 1, 3);

      // 4: C read never answered: watchdog releases in BUSY cycle 8
      seq_lat = 0;
      c_raddr = 15'h0055; c_rreq = 2'b01;
      tick();
      wait_idle("t4", 20);
      chk("t4_rdone_cycle", t_cr - start_cyc + 1, TO);
      chk("t4_err", err, 1);
      chk("t4_rreq", m_rreq, 0);
      tick();
      chk("t4_err_sticky", err, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t4_err_clr", err, 0);
      seq_lat = 3;
      d_waddr = 15'h0321; d_wdata = 16'h1357; d_wmask = 2'b10;
      tick();
      chk("t4_d_owner", owner, 1);
      chk("t4_d_wmask", m_wmask, 2'b10);
      wait_idle("t4d", 20);
      chk("t4_d_wdone_cycle", t_dw - start_cyc + 1, 3);
      chk("t4_err_after", err, 0);

      // 5: ena dropped mid C write; pending D waits for ena
      seq_lat = 5;
      c_waddr = 15'h0777; c_wdata = 16'h0f0f; c_wmask = 2'b01;
      tick();
      d_raddr = 15'h0444; d_rreq = 2'b11;
      tick();
      ena = 1'b0;
      wait_idle("t5", 20);
      chk("t5_wdone_cycle", t_cw - start_cyc + 1, 5);
      repeat (3) tick();
      chk("t5_no_grant", busy, 0);
      ena = 1'b1;
      tick();
      chk("t5_d_busy", busy, 1);
      chk("t5_d_owner", owner, 1);
      chk("t5_d_rreq", m_rreq, 2'b11);
      wait_idle("t5d", 20);

      // 6: reset while BUSY, then C wins the tie
      seq_lat = 6;
      c_raddr = 15'h0099; c_rreq = 2'b01;
      tick();
      tick();
      d_waddr = 15'h0aaa; d_wdata = 16'h2468; d_wmask = 2'b11;
      #2;
      rst_n = 1'b0;
      m_wdone = 1'b0; m_rdone = 1'b0; age = 0;
      model_reset();
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_req", {m_rreq, m_wmask}, 0);
      chk("t6_addr", {m_raddr, m_waddr}, 0);
      chk("t6_owner", owner, 0);
      chk("t6_done", {c_rdone, c_wdone, d_rdone, d_wdone}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_first_owner", owner, 0);
      chk("t6_first_rreq", m_rreq, 2'b01);
      drain("t6", 40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
